// File: rtl/fetch_unit_pkg.sv
// Shared core definitions for the instruction fetch stage: widths, reset PC
// and the (pc, instr) payload carried through the fetch buffer.
package fetch_unit_pkg;

  localparam int unsigned XLEN            = 32;
  localparam logic [XLEN-1:0] RESET_PC    = '0;
  localparam int unsigned FETCH_BUF_DEPTH = 2;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buf.sv
// Two-entry FIFO of fetched (pc, instr) pairs. Overflow is prevented
// upstream by fetch credit, so there is no full-side backpressure.
module fetch_buf
  import fetch_unit_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  fetch_entry_t push_data_i,
  input  logic         pop_i,
  input  logic         flush_i,
  output logic         valid_o,
  output fetch_entry_t head_o,
  output logic [1:0]   count_o
);

  fetch_entry_t mem_q [2];
  fetch_entry_t mem_d [2];
  logic         rd_q, rd_d;
  logic         wr_q, wr_d;
  logic [1:0]   count_q, count_d;
  logic         push_c, pop_c;

  // Flush wins over push/pop; a pop on an empty buffer is ignored.
  always_comb begin
    push_c  = push_i & ~flush_i;
    pop_c   = pop_i & (count_q != 2'd0);
    mem_d   = mem_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    count_d = count_q;
    if (flush_i) begin
      rd_d    = 1'b0;
      wr_d    = 1'b0;
      count_d = 2'd0;
    end else begin
      if (push_c) begin
        mem_d[wr_q] = push_data_i;
        wr_d        = ~wr_q;
      end
      if (pop_c) begin
        rd_d = ~rd_q;
      end
      count_d = count_q + 2'(push_c) - 2'(pop_c);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q   <= '{default: '0};
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      count_q <= 2'd0;
    end else begin
      mem_q   <= mem_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
    end
  end

  assign valid_o = (count_q != 2'd0);
  assign head_o  = mem_q[rd_q];
  assign count_o = count_q;

  a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n)
    !(push_i && !flush_i && count_q == 2'd2));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one iram read per cycle while
// buffer credit allows, and hands (pc, instr) pairs to decode.
module fetch_unit
  import fetch_unit_pkg::fetch_entry_t;
#(
  parameter int unsigned     XLEN      = fetch_unit_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC  = fetch_unit_pkg::RESET_PC,
  parameter int unsigned     BUF_DEPTH = fetch_unit_pkg::FETCH_BUF_DEPTH
) (
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] iram_addr,
  output logic            iram_en,
  input  logic [XLEN-1:0] iram_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_instr
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;
  logic            inflight_q, inflight_d;

  logic [XLEN-1:0] fetch_pc_c;
  logic [2:0]      occ_c;
  logic            pop_c, push_c, issue_c;
  logic [1:0]      buf_count;
  fetch_entry_t    push_entry;
  fetch_entry_t    head;

  // Credit counts buffered plus in-flight words; a redirect always issues
  // because it flushes the buffer and kills the in-flight response.
  always_comb begin
    pop_c         = if_valid & if_ready;
    push_c        = inflight_q & ~redirect_valid;
    occ_c         = 3'(buf_count) + 3'(inflight_q) - 3'(pop_c);
    fetch_pc_c    = redirect_valid ? (redirect_pc & ~XLEN'(3)) : pc_q;
    issue_c       = redirect_valid | (occ_c < 3'(BUF_DEPTH));
    pc_d          = pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    if (issue_c) begin
      pc_d          = fetch_pc_c + XLEN'(4);
      inflight_d    = 1'b1;
      inflight_pc_d = fetch_pc_c;
    end
    iram_en   = rst & issue_c;
    iram_addr = rst ? (fetch_pc_c >> 2) : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  assign push_entry = '{pc: inflight_pc_q, instr: iram_rdata};

  fetch_buf u_fetch_buf (
    .clk         (clk),
    .rst_n       (rst),
    .push_i      (push_c),
    .push_data_i (push_entry),
    .pop_i       (pop_c),
    .flush_i     (redirect_valid),
    .valid_o     (if_valid),
    .head_o      (head),
    .count_o     (buf_count)
  );

  assign if_pc    = head.pc;
  assign if_instr = head.instr;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit with a registered iram model and a
// PC-sequence scoreboard for randomized ready/redirect traffic.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] iram_addr;
  logic        iram_en;
  logic [31:0] iram_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;

  int total = 0;
  int bad   = 0;

  fetch_unit #(.XLEN(32), .RESET_PC(32'h100), .BUF_DEPTH(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .iram_addr      (iram_addr),
    .iram_en        (iram_en),
    .iram_rdata     (iram_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_instr       (if_instr)
  );

  always #5 clk = ~clk;

  // iram contents: a bijective hash of the word index.
  function automatic logic [31:0] mem_word(input logic [31:0] idx);
    return (idx * 32'h9E37_79B1) ^ 32'hC0FF_EE11;
  endfunction

  function automatic logic [31:0] word_of(input logic [31:0] pc);
    return mem_word(pc >> 2);
  endfunction

  always @(posedge clk) begin
    if (iram_en) iram_rdata <= mem_word(iram_addr);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rdy, input logic rv, input logic [31:0] rpc);
    if_ready       = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    if_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    cyc();
    cyc();
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    total++;
    if (iram_en !== 1'b0 || iram_addr !== 32'h0) begin
      bad++; $display("FAIL reset_iram: en=%b addr=%h required en=0 addr=0", iram_en, iram_addr);
    end
    total++;
    if (if_valid !== 1'b0 || if_pc !== 32'h0 || if_instr !== 32'h0) begin
      bad++; $display("FAIL reset_if: valid=%b pc=%h instr=%h required 0/0/0", if_valid, if_pc, if_instr);
    end
  endtask

  task automatic test_startup();
    logic [31:0] exp_pc;
    do_reset();
    cyc();
    rst = 1'b1;
    drive(1'b1, 1'b0, 32'h0);
    for (int c = 0; c < 6; c++) begin
      total++;
      if (iram_en !== 1'b1 || iram_addr !== 32'h40 + 32'(c)) begin
        bad++; $display("FAIL startup_addr c%0d: en=%b addr=%h required en=1 addr=%h", c, iram_en, iram_addr, 32'h40 + 32'(c));
      end
      exp_pc = 32'h100 + 32'(4 * (c - 2));
      if (c < 2) begin
        total++;
        if (if_valid !== 1'b0) begin
          bad++; $display("FAIL startup_valid c%0d: valid=%b required 0", c, if_valid);
        end
      end else begin
        total++;
        if (if_valid !== 1'b1 || if_pc !== exp_pc || if_instr !== word_of(exp_pc)) begin
          bad++; $display("FAIL startup_if c%0d: valid=%b pc=%h instr=%h required pc=%h instr=%h",
                          c, if_valid, if_pc, if_instr, exp_pc, word_of(exp_pc));
        end
      end
      cyc();
      #1;
    end
  endtask

  task automatic test_stall();
    int issues;
    logic [31:0] exp_pc;
    do_reset();
    cyc();
    rst = 1'b1;
    drive(1'b0, 1'b0, 32'h0);
    issues = 0;
    for (int c = 0; c < 10; c++) begin
      if (iram_en) issues++;
      if (c < 9) begin cyc(); #1; end
    end
    total++;
    if (issues != 2) begin
      bad++; $display("FAIL stall_issues: got=%0d required 2", issues);
    end
    total++;
    if (if_valid !== 1'b1 || if_pc !== 32'h100 || iram_en !== 1'b0) begin
      bad++; $display("FAIL stall_hold: valid=%b pc=%h en=%b required 1/00000100/0", if_valid, if_pc, iram_en);
    end
    cyc();
    drive(1'b1, 1'b0, 32'h0);
    total++;
    if (iram_en !== 1'b1 || iram_addr !== 32'h42) begin
      bad++; $display("FAIL stall_resume_addr: en=%b addr=%h required 1/00000042", iram_en, iram_addr);
    end
    for (int c = 0; c < 5; c++) begin
      exp_pc = 32'h100 + 32'(4 * c);
      total++;
      if (if_valid !== 1'b1 || if_pc !== exp_pc || if_instr !== word_of(exp_pc)) begin
        bad++; $display("FAIL stall_drain c%0d: valid=%b pc=%h required pc=%h", c, if_valid, if_pc, exp_pc);
      end
      cyc();
      #1;
    end
  endtask

  task automatic test_redirect();
    do_reset();
    cyc();
    rst = 1'b1;
    drive(1'b0, 1'b0, 32'h0);
    cyc(); cyc(); cyc(); #1;
    cyc();
    drive(1'b1, 1'b0, 32'h0);
    cyc();
    drive(1'b0, 1'b1, 32'h2003);
    total++;
    if (iram_en !== 1'b1 || iram_addr !== 32'h800) begin
      bad++; $display("FAIL redir_issue: en=%b addr=%h required 1/00000800", iram_en, iram_addr);
    end
    cyc();
    drive(1'b0, 1'b0, 32'h0);
    total++;
    if (if_valid !== 1'b0) begin
      bad++; $display("FAIL redir_bubble: valid=%b pc=%h required valid=0", if_valid, if_pc);
    end
    cyc();
    drive(1'b1, 1'b0, 32'h0);
    total++;
    if (if_valid !== 1'b1 || if_pc !== 32'h2000 || if_instr !== word_of(32'h2000)) begin
      bad++; $display("FAIL redir_first: valid=%b pc=%h required pc=00002000", if_valid, if_pc);
    end
    cyc();
    #1;
    total++;
    if (if_valid !== 1'b1 || if_pc !== 32'h2004 || if_instr !== word_of(32'h2004)) begin
      bad++; $display("FAIL redir_second: valid=%b pc=%h required pc=00002004", if_valid, if_pc);
    end
  endtask

  task automatic test_back_to_back();
    cyc();
    drive(1'b1, 1'b1, 32'h400);
    cyc();
    drive(1'b1, 1'b1, 32'h800);
    total++;
    if (if_valid !== 1'b0) begin
      bad++; $display("FAIL b2b_t1: valid=%b pc=%h required valid=0", if_valid, if_pc);
    end
    cyc();
    drive(1'b1, 1'b0, 32'h0);
    total++;
    if (if_valid !== 1'b0) begin
      bad++; $display("FAIL b2b_t2: valid=%b pc=%h required valid=0", if_valid, if_pc);
    end
    for (int c = 0; c < 3; c++) begin
      cyc();
      #1;
      total++;
      if (if_valid !== 1'b1 || if_pc !== 32'h800 + 32'(4 * c)) begin
        bad++; $display("FAIL b2b_stream c%0d: valid=%b pc=%h required pc=%h", c, if_valid, if_pc, 32'h800 + 32'(4 * c));
      end
    end
  endtask

  task automatic test_wrap();
    cyc();
    drive(1'b1, 1'b1, 32'hFFFF_FFFC);
    total++;
    if (iram_addr !== 32'h3FFF_FFFF) begin
      bad++; $display("FAIL wrap_addr0: addr=%h required 3fffffff", iram_addr);
    end
    cyc();
    drive(1'b1, 1'b0, 32'h0);
    total++;
    if (iram_en !== 1'b1 || iram_addr !== 32'h0) begin
      bad++; $display("FAIL wrap_addr1: en=%b addr=%h required 1/00000000", iram_en, iram_addr);
    end
    cyc();
    #1;
    total++;
    if (if_valid !== 1'b1 || if_pc !== 32'hFFFF_FFFC || if_instr !== word_of(32'hFFFF_FFFC)) begin
      bad++; $display("FAIL wrap_pc0: valid=%b pc=%h required fffffffc", if_valid, if_pc);
    end
    cyc();
    #1;
    total++;
    if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_instr !== word_of(32'h0)) begin
      bad++; $display("FAIL wrap_pc1: valid=%b pc=%h required 00000000", if_valid, if_pc);
    end
  endtask

  task automatic test_reset_midstream();
    cyc();
    rst = 1'b0;
    #1;
    total++;
    if (iram_en !== 1'b0 || iram_addr !== 32'h0 || if_valid !== 1'b0 || if_pc !== 32'h0 || if_instr !== 32'h0) begin
      bad++; $display("FAIL midreset: en=%b addr=%h valid=%b pc=%h instr=%h required all 0",
                      iram_en, iram_addr, if_valid, if_pc, if_instr);
    end
    cyc();
    rst = 1'b1;
    drive(1'b1, 1'b0, 32'h0);
    total++;
    if (iram_en !== 1'b1 || iram_addr !== 32'h40) begin
      bad++; $display("FAIL midreset_restart: en=%b addr=%h required 1/00000040", iram_en, iram_addr);
    end
    cyc();
    cyc();
    #1;
    total++;
    if (if_valid !== 1'b1 || if_pc !== 32'h100) begin
      bad++; $display("FAIL midreset_first: valid=%b pc=%h required 00000100", if_valid, if_pc);
    end
  endtask

  task automatic test_random();
    logic [31:0] exp_pc, prev_pc, prev_instr, rpc;
    logic        rdy, rv, prev_stall;
    int          since_redir;
    do_reset();
    cyc();
    rst = 1'b1;
    exp_pc = 32'h100;
    prev_stall = 1'b0;
    prev_pc = '0;
    prev_instr = '0;
    since_redir = 0;
    for (int n = 0; n < 4000; n++) begin
      if (n != 0) cyc();
      rdy = ($urandom_range(0, 2) != 0);
      rv  = (n > 3) && ($urandom_range(0, 24) == 0);
      rpc = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      drive(rdy, rv, rpc);
      if (since_redir == 1) begin
        total++;
        if (if_valid !== 1'b0) begin
          bad++; $display("FAIL rnd_bubble n%0d: valid=%b required 0", n, if_valid);
        end
      end else if (since_redir == 2) begin
        total++;
        if (if_valid !== 1'b1) begin
          bad++; $display("FAIL rnd_latency n%0d: valid=%b required 1", n, if_valid);
        end
      end
      if (prev_stall) begin
        total++;
        if (if_valid !== 1'b1 || if_pc !== prev_pc || if_instr !== prev_instr) begin
          bad++; $display("FAIL rnd_stable n%0d: valid=%b pc=%h instr=%h required pc=%h instr=%h",
                          n, if_valid, if_pc, if_instr, prev_pc, prev_instr);
        end
      end
      if (if_valid === 1'b1) begin
        total++;
        if (if_pc !== exp_pc || if_instr !== word_of(exp_pc)) begin
          bad++; $display("FAIL rnd_seq n%0d: pc=%h instr=%h required pc=%h instr=%h",
                          n, if_pc, if_instr, exp_pc, word_of(exp_pc));
        end
      end
      prev_stall = (if_valid === 1'b1) && !rdy && !rv;
      prev_pc    = if_pc;
      prev_instr = if_instr;
      if ((if_valid === 1'b1) && rdy) exp_pc = exp_pc + 32'd4;
      if (rv) begin
        exp_pc = rpc & ~32'd3;
        since_redir = 1;
      end else if (since_redir == 2) begin
        since_redir = 0;
      end else if (since_redir != 0) begin
        since_redir++;
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    if_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    test_reset();
    test_startup();
    test_stall();
    test_redirect();
    test_back_to_back();
    test_wrap();
    test_reset_midstream();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
